// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/mret sequencer.
// Accepts one interrupt, exception or mret while idle, then issues the
// required CSR writes one per cycle and offers a redirect to fetch that
// holds until it is accepted.
module trap_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            irq_req,
   input  logic            illegal_req,
   input  logic            ecall_req,
   input  logic            mret_req,
   input  logic [XLEN-1:0] cur_pc,
   input  logic [XLEN-1:0] mstatus_in,
   input  logic [XLEN-1:0] mtvec_in,
   input  logic [XLEN-1:0] mepc_in,
   output logic            csr_wen,
   output logic [11:0]     csr_waddr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            busy,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            redirect_ready
);

   typedef enum logic [2:0] {
      IDLE, W_EPC, W_CAUSE, W_STATUS, W_RET, REDIRECT
   } state_t;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   // Interrupt causes carry the MSB set; the low bits are the cause code.
   localparam logic [XLEN-1:0] CAUSE_IRQ     = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(7);
   localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
   localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);

   state_t          state, state_nxt;
   logic [XLEN-1:0] epc_q, cause_q, cause_nxt;
   logic            take_trap, take_mret;
   logic [XLEN-1:0] status_trap, status_ret;

   // The vector base is word aligned, so its mode bits are deliberately dropped.
   logic unused_mtvec_mode;
   assign unused_mtvec_mode = ^mtvec_in[1:0];

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value regardless of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic with request arbitration; requests only matter in IDLE.
   // NOTE: every signal driven here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      take_trap = 1'b0;
      take_mret = 1'b0;
      cause_nxt = '0;
      case (state)
         IDLE: begin
            if (irq_req && mstatus_in[3]) begin
               take_trap = 1'b1;
               cause_nxt = CAUSE_IRQ;
            end else if (illegal_req) begin
               take_trap = 1'b1;
               cause_nxt = CAUSE_ILLEGAL;
            end else if (ecall_req) begin
               take_trap = 1'b1;
               cause_nxt = CAUSE_ECALL;
            end else if (mret_req) begin
               take_mret = 1'b1;
            end
            if (take_trap)      state_nxt = W_EPC;
            else if (take_mret) state_nxt = W_RET;
         end
         W_EPC:    state_nxt = W_CAUSE;
         W_CAUSE:  state_nxt = W_STATUS;
         W_STATUS: state_nxt = REDIRECT;
         W_RET:    state_nxt = REDIRECT;
         REDIRECT: if (redirect_ready) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Trap context and redirect target capture; the target is latched on the
   // edge into REDIRECT so it cannot move while it is being offered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         epc_q       <= '0;
         cause_q     <= '0;
         redirect_pc <= '0;
      end else begin
         if (take_trap) begin
            epc_q   <= cur_pc;
            cause_q <= cause_nxt;
         end
         if (state == W_STATUS)   redirect_pc <= {mtvec_in[XLEN-1:2], 2'b00};
         else if (state == W_RET) redirect_pc <= mepc_in;
      end
   end

   // Moore outputs: status update values and the per-state CSR write.
   always_comb begin
      status_trap        = mstatus_in;
      status_trap[7]     = mstatus_in[3];
      status_trap[3]     = 1'b0;
      status_trap[12:11] = 2'b11;

      status_ret         = mstatus_in;
      status_ret[3]      = mstatus_in[7];
      status_ret[7]      = 1'b1;
      status_ret[12:11]  = 2'b11;

      busy           = (state != IDLE);
      redirect_valid = (state == REDIRECT);
      csr_wen        = 1'b0;
      csr_waddr      = '0;
      csr_wdata      = '0;
      case (state)
         W_EPC: begin
            csr_wen   = 1'b1;
            csr_waddr = CSR_MEPC;
            csr_wdata = epc_q;
         end
         W_CAUSE: begin
            csr_wen   = 1'b1;
            csr_waddr = CSR_MCAUSE;
            csr_wdata = cause_q;
         end
         W_STATUS: begin
            csr_wen   = 1'b1;
            csr_waddr = CSR_MSTATUS;
            csr_wdata = status_trap;
         end
         W_RET: begin
            csr_wen   = 1'b1;
            csr_waddr = CSR_MSTATUS;
            csr_wdata = status_ret;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scenario tasks for trap_ctrl. Expected CSR writes are queued
// when a request is driven and popped by a negedge monitor as writes appear.
module tb_trap_ctrl;

   localparam int XLEN = 32;

   typedef struct packed {
      logic [11:0]     addr;
      logic [XLEN-1:0] data;
   } wr_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            irq_req = 1'b0, illegal_req = 1'b0, ecall_req = 1'b0, mret_req = 1'b0;
   logic [XLEN-1:0] cur_pc = '0, mstatus_in = '0, mtvec_in = '0, mepc_in = '0;
   logic            redirect_ready = 1'b0;
   logic            csr_wen, busy, redirect_valid;
   logic [11:0]     csr_waddr;
   logic [XLEN-1:0] csr_wdata, redirect_pc;

   wr_t exp_q[$];
   int  n_pass  = 0;
   int  n_total = 0;

   trap_ctrl #(.XLEN(XLEN)) dut (
      .clk            (clk),
      .rst            (rst),
      .irq_req        (irq_req),
      .illegal_req    (illegal_req),
      .ecall_req      (ecall_req),
      .mret_req       (mret_req),
      .cur_pc         (cur_pc),
      .mstatus_in     (mstatus_in),
      .mtvec_in       (mtvec_in),
      .mepc_in        (mepc_in),
      .csr_wen        (csr_wen),
      .csr_waddr      (csr_waddr),
      .csr_wdata      (csr_wdata),
      .busy           (busy),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: each write must match the head of the queue; idle
   // cycles must show a zeroed address and data.
   always @(negedge clk) begin
      if (csr_wen === 1'b1) begin
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL csr_write_unexpected got addr=%h data=%h want no write", csr_waddr, csr_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if ({csr_waddr, csr_wdata} !== e)
               $display("FAIL csr_write got addr=%h data=%h want addr=%h data=%h",
                        csr_waddr, csr_wdata, e.addr, e.data);
            else n_pass++;
         end
      end else begin
         n_total++;
         if (csr_wen !== 1'b0 || csr_waddr !== 12'h0 || csr_wdata !== '0)
            $display("FAIL csr_idle_zero got wen=%b addr=%h data=%h want 0/0/0", csr_wen, csr_waddr, csr_wdata);
         else n_pass++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic [11:0] a, input logic [XLEN-1:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic test_reset();
      #2;
      n_total++;
      if ({busy, csr_wen, redirect_valid} !== 3'b000 || redirect_pc !== '0 || csr_waddr !== 12'h0)
         $display("FAIL reset_outputs got busy=%b wen=%b rv=%b rpc=%h want all 0", busy, csr_wen, redirect_valid, redirect_pc);
      else n_pass++;
      @(negedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_ecall();
      cur_pc = 32'h80000100; mstatus_in = 32'h8; mtvec_in = 32'h80000201; redirect_ready = 1'b1;
      push_wr(12'h341, 32'h80000100);
      push_wr(12'h342, 32'h0000000B);
      push_wr(12'h300, 32'h00001880);
      ecall_req = 1'b1;
      next_cycle();
      ecall_req = 1'b0;
      n_total++;
      if (busy !== 1'b1 || redirect_valid !== 1'b0)
         $display("FAIL ecall_busy got busy=%b rv=%b want 1/0", busy, redirect_valid);
      else n_pass++;
      next_cycle();
      next_cycle();
      n_total++;
      if (redirect_valid !== 1'b0)
         $display("FAIL ecall_rv_early got %b want 0", redirect_valid);
      else n_pass++;
      next_cycle();
      n_total++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80000200)
         $display("FAIL ecall_redirect got rv=%b pc=%h want 1/80000200", redirect_valid, redirect_pc);
      else n_pass++;
      next_cycle();
      n_total++;
      if (busy !== 1'b0 || redirect_valid !== 1'b0 || exp_q.size() != 0)
         $display("FAIL ecall_done got busy=%b rv=%b pending=%0d want 0/0/0", busy, redirect_valid, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_mret();
      mstatus_in = 32'h1880; mepc_in = 32'h80000104; redirect_ready = 1'b1;
      push_wr(12'h300, 32'h00001888);
      mret_req = 1'b1;
      next_cycle();
      mret_req = 1'b0;
      n_total++;
      if (busy !== 1'b1 || redirect_valid !== 1'b0)
         $display("FAIL mret_wret got busy=%b rv=%b want 1/0", busy, redirect_valid);
      else n_pass++;
      next_cycle();
      n_total++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80000104)
         $display("FAIL mret_redirect got rv=%b pc=%h want 1/80000104", redirect_valid, redirect_pc);
      else n_pass++;
      next_cycle();
      n_total++;
      if (busy !== 1'b0 || exp_q.size() != 0)
         $display("FAIL mret_done got busy=%b pending=%0d want 0/0", busy, exp_q.size());
      else n_pass++;
   endtask

   // Three simultaneous trap requests; status carries extra bits to show
   // that only MIE/MPIE/MPP change.
   task automatic test_priority(input logic mie, input logic [XLEN-1:0] exp_cause,
                                input logic [XLEN-1:0] exp_status);
      cur_pc = 32'h80000180; mstatus_in = mie ? 32'hA008 : 32'hA000;
      mtvec_in = 32'h80000000; redirect_ready = 1'b1;
      push_wr(12'h341, 32'h80000180);
      push_wr(12'h342, exp_cause);
      push_wr(12'h300, exp_status);
      irq_req = 1'b1; illegal_req = 1'b1; ecall_req = 1'b1;
      next_cycle();
      irq_req = 1'b0; illegal_req = 1'b0; ecall_req = 1'b0;
      repeat (3) next_cycle();
      n_total++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80000000)
         $display("FAIL prio_redirect got rv=%b pc=%h want 1/80000000", redirect_valid, redirect_pc);
      else n_pass++;
      next_cycle();
      n_total++;
      if (busy !== 1'b0 || exp_q.size() != 0)
         $display("FAIL prio_done got busy=%b pending=%0d want 0/0", busy, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_irq_masked();
      mstatus_in = 32'h0;
      irq_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         n_total++;
         if (busy !== 1'b0)
            $display("FAIL irq_masked got busy=%b want 0", busy);
         else n_pass++;
      end
      irq_req = 1'b0;
   endtask

   // Redirect held off for 5 cycles with a stray ecall, then an mret present
   // during the handshake cycle must wait for the following edge.
   task automatic test_ready_hold();
      cur_pc = 32'h80000300; mstatus_in = 32'h8; mtvec_in = 32'h80000400;
      mepc_in = 32'h80000500; redirect_ready = 1'b0;
      push_wr(12'h341, 32'h80000300);
      push_wr(12'h342, 32'h0000000B);
      push_wr(12'h300, 32'h00001880);
      ecall_req = 1'b1;
      next_cycle();
      ecall_req = 1'b0;
      repeat (3) next_cycle();
      ecall_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_total++;
         if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80000400 || busy !== 1'b1)
            $display("FAIL hold_stable got rv=%b pc=%h busy=%b want 1/80000400/1", redirect_valid, redirect_pc, busy);
         else n_pass++;
         next_cycle();
      end
      ecall_req = 1'b0;
      mret_req = 1'b1;
      redirect_ready = 1'b1;
      push_wr(12'h300, 32'h00001880);
      next_cycle();
      n_total++;
      if (busy !== 1'b0 || redirect_valid !== 1'b0)
         $display("FAIL handshake_idle got busy=%b rv=%b want 0/0", busy, redirect_valid);
      else n_pass++;
      next_cycle();
      mret_req = 1'b0;
      n_total++;
      if (busy !== 1'b1 || redirect_valid !== 1'b0)
         $display("FAIL back_to_back_mret got busy=%b rv=%b want 1/0", busy, redirect_valid);
      else n_pass++;
      next_cycle();
      n_total++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80000500)
         $display("FAIL back_to_back_redirect got rv=%b pc=%h want 1/80000500", redirect_valid, redirect_pc);
      else n_pass++;
      next_cycle();
      n_total++;
      if (busy !== 1'b0 || exp_q.size() != 0)
         $display("FAIL hold_done got busy=%b pending=%0d want 0/0", busy, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid_seq();
      cur_pc = 32'h80000600; mstatus_in = 32'h8; mtvec_in = 32'h80000700; redirect_ready = 1'b1;
      push_wr(12'h341, 32'h80000600);
      push_wr(12'h342, 32'h0000000B);
      ecall_req = 1'b1;
      next_cycle();
      ecall_req = 1'b0;
      next_cycle();
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      n_total++;
      if ({busy, csr_wen, redirect_valid} !== 3'b000 || csr_waddr !== 12'h0 || redirect_pc !== '0)
         $display("FAIL midreset_outputs got busy=%b wen=%b rv=%b addr=%h rpc=%h want all 0",
                  busy, csr_wen, redirect_valid, csr_waddr, redirect_pc);
      else n_pass++;
      repeat (2) next_cycle();
      n_total++;
      if (busy !== 1'b0 || exp_q.size() != 0)
         $display("FAIL midreset_no_status got busy=%b pending=%0d want 0/0", busy, exp_q.size());
      else n_pass++;
      cur_pc = 32'h80000800;
      push_wr(12'h341, 32'h80000800);
      push_wr(12'h342, 32'h0000000B);
      push_wr(12'h300, 32'h00001880);
      ecall_req = 1'b1;
      @(negedge clk);
      #1 rst = 1'b1;
      next_cycle();
      ecall_req = 1'b0;
      n_total++;
      if (busy !== 1'b1)
         $display("FAIL post_reset_accept got busy=%b want 1", busy);
      else n_pass++;
      repeat (3) next_cycle();
      n_total++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80000700)
         $display("FAIL post_reset_redirect got rv=%b pc=%h want 1/80000700", redirect_valid, redirect_pc);
      else n_pass++;
      next_cycle();
      n_total++;
      if (busy !== 1'b0 || exp_q.size() != 0)
         $display("FAIL post_reset_done got busy=%b pending=%0d want 0/0", busy, exp_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      next_cycle();
      test_ecall();
      test_mret();
      test_priority(1'b1, 32'h80000007, 32'h0000B880);
      test_priority(1'b0, 32'h00000002, 32'h0000B800);
      test_irq_masked();
      test_ready_hold();
      test_reset_mid_seq();
      next_cycle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have parameter: XLEN, 32, datapath and CSR width.
REQ-002 The block SHALL have ports (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- irq_req  in  1  level timer-interrupt request.
- illegal_req  in  1  illegal-instruction exception request.
- ecall_req  in  1  ecall retiring.
- mret_req  in  1  mret retiring.
- cur_pc  in  XLEN  PC of the retiring instruction.
- mstatus_in  in  XLEN  current mstatus from CSR file.
- mtvec_in  in  XLEN  current mtvec.
- mepc_in  in  XLEN  current mepc.
- csr_wen  out  1  CSR write strobe.
- csr_waddr  out  12  CSR address.
- csr_wdata  out  XLEN  CSR write data.
- busy  out  1  stall fetch/issue.
- redirect_valid  out  1  redirect offer.
- redirect_pc  out  XLEN  redirect target.
- redirect_ready  in  1  fetch accepts redirect.

Function
REQ-003 States SHALL be IDLE, W_EPC, W_CAUSE, W_STATUS, W_RET, REDIRECT; busy SHALL be 1 in every state except IDLE.
REQ-004 Requests SHALL be sampled only in IDLE; requests seen in any other state SHALL be ignored, not queued.
REQ-005 Priority for simultaneous requests SHALL be: irq_req (only when mstatus_in[3]=1) > illegal_req > ecall_req > mret_req.
REQ-006 On acceptance of a trap, the block SHALL latch cur_pc and cause; cause SHALL be 0x80000007 for irq, 0x2 for illegal, 0xB for ecall.
REQ-007 The trap path SHALL be IDLE->W_EPC->W_CAUSE->W_STATUS->REDIRECT, one cycle per write state.
REQ-008 The block SHALL write in W_EPC: csr_waddr 0x341, csr_wdata latched PC.
REQ-009 The block SHALL write in W_CAUSE: 0x342, latched cause.
REQ-010 The block SHALL write in W_STATUS: 0x300, mstatus_in with MPIE(bit7)=MIE(bit3), MIE=0, MPP(bits12:11)=2'b11, other bits unchanged.
REQ-011 The mret path SHALL be IDLE->W_RET->REDIRECT.
REQ-012 W_RET SHALL write 0x300 with MIE=MPIE, MPIE=1, MPP=2'b11, other bits unchanged.
REQ-013 csr_wen SHALL be 1 only in W_EPC, W_CAUSE, W_STATUS, W_RET: exactly 3 writes per trap, 1 per mret.
REQ-014 csr_waddr and csr_wdata SHALL be 0 whenever csr_wen=0.
REQ-015 On the transition into REDIRECT, redirect_pc SHALL be latched as {mtvec_in[XLEN-1:2],2'b00} for a trap, or mepc_in for mret.
REQ-016 redirect_pc SHALL stay stable while redirect_valid=1.
REQ-017 redirect_valid SHALL be 1 exactly in REDIRECT and SHALL hold until redirect_ready=1.
REQ-018 When redirect_valid=1 and redirect_ready=1 on a cycle, the state SHALL return to IDLE on the next edge, and no new request SHALL be accepted in that same cycle.
REQ-019 Latency, acceptance at edge N: trap writes SHALL occur in cycles N+1..N+3 with redirect_valid from N+4; mret write SHALL occur in N+1 with redirect_valid from N+2.
REQ-020 irq_req with MIE=0 SHALL be ignored, and a lower-priority request present in the same cycle SHALL be served.

Reset
REQ-021 On rst=0, asynchronously: state SHALL go to IDLE, latched PC/cause/redirect_pc SHALL be 0, and all outputs SHALL be 0 (busy=0, csr_wen=0, redirect_valid=0).
REQ-022 Reset asserted mid-sequence SHALL abort it with no further CSR writes; after rst deassertion, the first edge SHALL sample requests from IDLE.

Verification
REQ-023 The bench SHALL cover these scenarios:
- ecall_req=1, cur_pc=0x80000100, mstatus_in=0x8, mtvec_in=0x80000201, ready=1 -> writes (0x341,0x80000100), (0x342,0xB), (0x300,0x1880), then redirect_pc=0x80000200, busy drops after handshake.
- mret_req=1, mstatus_in=0x1880, mepc_in=0x80000104 -> single write (0x300,0x1888), redirect_pc=0x80000104 two cycles after acceptance.
- irq_req+illegal_req+ecall_req together, MIE=1 -> cause 0x80000007; repeat with MIE=0 -> cause 0x2.
- redirect_ready held 0 for 5 cycles -> redirect_valid and redirect_pc stable, busy=1; a new ecall_req during the hold is ignored.
- rst=0 asserted in W_CAUSE -> outputs 0 immediately, no W_STATUS write; after release, a new ecall runs the full sequence.
